// File: rtl/pulse_mon_pkg.sv
// Shared constants for the 1 ms tick path: FSM encoding and default tick timing.
package pulse_mon_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACQ    = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

   typedef logic [1:0] mon_state_t;

   // Shared with the tick generator so both sides agree on the nominal period.
   localparam int DEF_EXP_PERIOD = 1000;
   localparam int DEF_TOL        = 2;

endpackage

// File: rtl/pulse_edge_det.sv
// Registers the tick input and produces a one-cycle strobe on its rising edge.
module pulse_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise
);

   logic pulse_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pulse_q <= 1'b0;
      else     pulse_q <= din;
   end

   assign rise = din & ~pulse_q;

endmodule

// File: rtl/pulse_period_mon.sv
// Tick interval monitor: measures spacing between tick edges, checks it against a
// tolerance window, tracks lock and counts early/late errors.
module pulse_period_mon
   import pulse_mon_pkg::*;
#(
   parameter int EXP_PERIOD = DEF_EXP_PERIOD,
   parameter int TOL        = DEF_TOL,
   parameter int LOCK_COUNT = 4,
   parameter int CNT_W      = 11,
   parameter int ERR_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pulse_in,
   input  logic             clr_err,
   output logic             locked,
   output logic             period_valid,
   output logic [CNT_W-1:0] period,
   output logic             err_early,
   output logic             err_late,
   output logic [ERR_W-1:0] err_count
);

   localparam int GR_W = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
   localparam logic [CNT_W-1:0] WIN_LO = CNT_W'(EXP_PERIOD - TOL);
   localparam logic [CNT_W-1:0] WIN_HI = CNT_W'(EXP_PERIOD + TOL);
   localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(EXP_PERIOD + TOL + 1);
   localparam logic [GR_W-1:0]  GR_LAST = GR_W'(LOCK_COUNT - 1);

   if (TOL >= EXP_PERIOD || EXP_PERIOD + TOL + 1 >= 2**CNT_W || LOCK_COUNT < 1) begin : g_param_err
      $error("pulse_period_mon: illegal parameter combination");
   end

   mon_state_t       state_q, state_d;
   logic [GR_W-1:0]  good_q, good_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             pv_q, pv_d, early_q, early_d, late_q, late_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic             ev, to, in_win, is_early;

   pulse_edge_det u_edge (
      .clk  (clk),
      .rst  (rst),
      .din  (pulse_in),
      .rise (ev)
   );

   assign to       = (state_q != ST_IDLE) && (cnt_q == TO_VAL);
   assign is_early = cnt_q < WIN_LO;
   assign in_win   = !is_early && (cnt_q <= WIN_HI);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         good_q  <= '0;
      end else begin
         state_q <= state_d;
         good_q  <= good_d;
      end
   end

   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      case (state_q)
         ST_IDLE: begin
            if (ev) begin
               state_d = ST_ACQ;
               good_d  = '0;
            end
         end
         ST_ACQ, ST_LOCKED: begin
            // A tick landing exactly on the timeout is a late error plus a fresh reference.
            if (to) begin
               state_d = ev ? ST_ACQ : ST_IDLE;
               good_d  = '0;
            end else if (ev) begin
               if (!in_win) begin
                  state_d = ST_ACQ;
                  good_d  = '0;
               end else if (state_q == ST_ACQ) begin
                  if (good_q == GR_LAST) begin
                     state_d = ST_LOCKED;
                     good_d  = '0;
                  end else begin
                     good_d = good_q + 1'b1;
                  end
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            good_d  = '0;
         end
      endcase
   end

   always_comb begin
      cnt_d    = ev ? CNT_W'(1) : ((&cnt_q) ? cnt_q : cnt_q + 1'b1);
      pv_d     = ev && !to && (state_q != ST_IDLE);
      early_d  = pv_d && is_early;
      late_d   = to;
      period_d = pv_d ? cnt_q : period_q;
      err_d    = err_q;
      if (clr_err)                           err_d = '0;
      else if ((early_d || late_d) && !(&err_q)) err_d = err_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         period_q <= '0;
         pv_q     <= 1'b0;
         early_q  <= 1'b0;
         late_q   <= 1'b0;
         err_q    <= '0;
      end else begin
         cnt_q    <= cnt_d;
         period_q <= period_d;
         pv_q     <= pv_d;
         early_q  <= early_d;
         late_q   <= late_d;
         err_q    <= err_d;
      end
   end

   assign locked       = (state_q == ST_LOCKED);
   assign period_valid = pv_q;
   assign period       = period_q;
   assign err_early    = early_q;
   assign err_late     = late_q;
   assign err_count    = err_q;

endmodule

// File: tb/tb_pulse_period_mon.sv
// Scoreboard bench for pulse_period_mon: each tick pushes its expected strobe, a
// negedge monitor pops and compares as the DUT reports.
module tb_pulse_period_mon;

   localparam int CNT_W = 11;
   localparam int ERR_W = 8;
   localparam int K_REF = 0, K_PER = 1, K_EARLY = 2, K_COINC = 3;

   logic             clk = 1'b0, rst = 1'b1, pulse_in = 1'b0, clr_err = 1'b0;
   logic             locked, period_valid, err_early, err_late;
   logic [CNT_W-1:0] period;
   logic [ERR_W-1:0] err_count;

   typedef struct {
      bit     pv;
      bit     early;
      bit     late;
      int     per;
      longint cyc;
   } exp_t;

   exp_t   sb_q[$];
   exp_t   mon_e;
   longint cyc = 0;
   longint last_ev = 0;
   int     n_vec = 0, n_err = 0;

   pulse_period_mon #(
      .EXP_PERIOD(1000), .TOL(2), .LOCK_COUNT(4), .CNT_W(CNT_W), .ERR_W(ERR_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .pulse_in     (pulse_in),
      .clr_err      (clr_err),
      .locked       (locked),
      .period_valid (period_valid),
      .period       (period),
      .err_early    (err_early),
      .err_late     (err_late),
      .err_count    (err_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input longint act, input longint exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Edge where the tick is sampled is ev_cyc; registered outputs show from that edge on.
   task automatic tick(input int gap, input int kind, input int per, input bit clr = 1'b0);
      exp_t e;
      while (cyc < last_ev + gap - 1) @(negedge clk);
      pulse_in = 1'b1;
      clr_err  = clr;
      last_ev  = cyc + 1;
      e.pv = 0; e.early = 0; e.late = 0; e.per = per; e.cyc = last_ev;
      case (kind)
         K_PER:   e.pv = 1;
         K_EARLY: begin e.pv = 1; e.early = 1; end
         K_COINC: e.late = 1;
         default: ;
      endcase
      if (kind != K_REF) sb_q.push_back(e);
      @(negedge clk);
      pulse_in = 1'b0;
      clr_err  = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            chk("missed_out", 0, sb_q[0].cyc);
            void'(sb_q.pop_front());
         end
         if (period_valid || err_early || err_late) begin
            if (sb_q.size() == 0) chk("unexpected_out", cyc, -1);
            else begin
               mon_e = sb_q.pop_front();
               chk("out_cycle", cyc, mon_e.cyc);
               chk("period_valid", period_valid, mon_e.pv);
               chk("err_early", err_early, mon_e.early);
               chk("err_late", err_late, mon_e.late);
               if (mon_e.pv) chk("period", period, mon_e.per);
            end
         end
      end
   end

   initial begin
      exp_t e;
      repeat (3) @(negedge clk);
      chk("rst_locked", locked, 0);
      chk("rst_pv", period_valid, 0);
      chk("rst_period", period, 0);
      chk("rst_errcnt", err_count, 0);
      rst = 1'b0;
      @(negedge clk);

      // Acquire lock on nominal ticks
      last_ev = cyc;
      tick(2, K_REF, 0);
      for (int i = 0; i < 3; i++) tick(1000, K_PER, 1000);
      chk("lock_not_yet", locked, 0);
      tick(1000, K_PER, 1000);
      chk("lock_5th", locked, 1);
      chk("lock_errcnt", err_count, 0);

      // Window edges
      tick(998, K_PER, 998);
      tick(1002, K_PER, 1002);
      chk("win_locked", locked, 1);
      chk("win_errcnt", err_count, 0);

      // Early tick and relock
      tick(997, K_EARLY, 997);
      chk("early_unlock", locked, 0);
      chk("early_errcnt", err_count, 1);
      for (int i = 0; i < 3; i++) tick(1000, K_PER, 1000);
      chk("relock_not_yet", locked, 0);
      tick(1000, K_PER, 1000);
      chk("relock", locked, 1);

      // Missing tick
      e.pv = 0; e.early = 0; e.late = 1; e.per = 0; e.cyc = last_ev + 1003;
      sb_q.push_back(e);
      while (cyc < last_ev + 1010) @(negedge clk);
      chk("late_unlock", locked, 0);
      chk("late_errcnt", err_count, 2);
      tick(1500, K_REF, 0);
      tick(1000, K_PER, 1000);
      for (int i = 0; i < 3; i++) tick(1000, K_PER, 1000);
      chk("late_relock", locked, 1);

      // Tick coincident with the timeout
      tick(1003, K_COINC, 0);
      chk("coinc_unlock", locked, 0);
      chk("coinc_errcnt", err_count, 3);
      tick(1000, K_PER, 1000);

      // Error counter saturation
      for (int i = 0; i < 260; i++) tick(10, K_EARLY, 10);
      chk("errcnt_sat", err_count, 255);

      // Clear coincident with an error
      tick(10, K_EARLY, 10, 1'b1);
      chk("clr_priority", err_count, 0);
      tick(500, K_EARLY, 500);
      chk("errcnt_after_clr", err_count, 1);
      for (int i = 0; i < 4; i++) tick(1000, K_PER, 1000);
      chk("pre_rst_locked", locked, 1);

      // Asynchronous reset mid-cycle while locked
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_locked", locked, 0);
      chk("arst_errcnt", err_count, 0);
      chk("arst_period", period, 0);
      chk("arst_pv", period_valid | err_early | err_late, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      last_ev = cyc;
      tick(2, K_REF, 0);
      tick(1000, K_PER, 1000);
      repeat (5) @(negedge clk);
      chk("post_rst_locked", locked, 0);
      chk("sb_empty", sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
